// File: rtl/sar_pkg.sv
// ============================================================================
// Module      : sar_pkg
// Description : Shared FSM state type, default parameters and width helper
//               for the SAR conversion controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_NCH        = 4;
  localparam int DEF_SAMPLE_CYC = 2;

  // A single channel still needs a one-bit select port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_bit_engine.sv
// ============================================================================
// Module      : sar_bit_engine
// Description : Successive-approximation trial/decide register. The trial
//               bit walks from MSB to LSB, and each comparator decision
//               keeps or drops the bit currently under test.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_bit_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             clr_i,
  input  logic             cmp_i,
  output logic [WIDTH-1:0] code_o,
  output logic [WIDTH-1:0] next_o,
  output logic             last_o
);

  localparam logic [WIDTH-1:0] C_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] code_d;

  // Resolve the bit under test, then raise the next lower trial bit.
  always_comb begin
    code_d = (cmp_i ? code_q : (code_q & ~mask_q)) | (mask_q >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      code_q <= '0;
      mask_q <= '0;
    end else if (load_i) begin
      code_q <= C_MSB;
      mask_q <= C_MSB;
    end else if (step_i) begin
      code_q <= code_d;
      mask_q <= mask_q >> 1;
    end
  end

  assign code_o = code_q;
  assign next_o = code_d;
  assign last_o = mask_q[0];

endmodule

`default_nettype wire

// File: rtl/sar_ctrl_param.sv
// ============================================================================
// Module      : sar_ctrl_param
// Description : Multi-channel SAR ADC controller with track phase, bitwise
//               conversion, and single-shot or round-robin scan modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_ctrl_param
  import sar_pkg::*;
#(
  parameter int  WIDTH      = DEF_WIDTH,
  parameter int  NCH        = DEF_NCH,
  parameter int  SAMPLE_CYC = DEF_SAMPLE_CYC,
  localparam int CHW        = ch_width(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             scan,
  input  logic [CHW-1:0]   ch_sel,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample,
  output logic [CHW-1:0]   ch,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [CHW-1:0]   result_ch,
  output logic             result_valid,
  output logic             err
);

  localparam int             SCW           = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam logic [SCW-1:0] C_SAMPLE_LAST = SCW'(SAMPLE_CYC - 1);
  localparam logic [CHW-1:0] C_CH_LAST     = CHW'(NCH - 1);
  localparam logic [CHW:0]   C_NCH         = (CHW+1)'(NCH);

  sar_state_t       state_q;
  logic [SCW-1:0]   scnt_q;
  logic             scan_mode_q;
  logic [CHW-1:0]   ch_q;
  logic             sample_q;
  logic             busy_q;
  logic [WIDTH-1:0] result_q;
  logic [CHW-1:0]   result_ch_q;
  logic             result_valid_q;
  logic             err_q;

  logic             eng_load;
  logic             eng_step;
  logic             eng_clr;
  logic             eng_last;
  logic [WIDTH-1:0] eng_code;
  logic [WIDTH-1:0] eng_next;

  assign eng_load = (state_q == SAMPLE) && (scnt_q == C_SAMPLE_LAST);
  assign eng_step = (state_q == CONVERT) && !eng_last;
  assign eng_clr  = (state_q == CONVERT) && eng_last;

  sar_bit_engine #(
    .WIDTH (WIDTH)
  ) u_engine (
    .clk    (clk),
    .rst    (rst),
    .load_i (eng_load),
    .step_i (eng_step),
    .clr_i  (eng_clr),
    .cmp_i  (cmp),
    .code_o (eng_code),
    .next_o (eng_next),
    .last_o (eng_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      scnt_q         <= '0;
      scan_mode_q    <= 1'b0;
      ch_q           <= '0;
      sample_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_ch_q    <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if ({1'b0, ch_sel} < C_NCH) begin
              state_q     <= SAMPLE;
              ch_q        <= ch_sel;
              scan_mode_q <= scan;
              scnt_q      <= '0;
              sample_q    <= 1'b1;
              busy_q      <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SAMPLE: begin
          if (scnt_q == C_SAMPLE_LAST) begin
            state_q  <= CONVERT;
            sample_q <= 1'b0;
          end else begin
            scnt_q <= scnt_q + 1'b1;
          end
        end
        CONVERT: begin
          if (eng_last) begin
            state_q        <= DONE;
            result_q       <= eng_next;
            result_ch_q    <= ch_q;
            result_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Scan continues only while both the latched mode and live input agree.
          if (scan_mode_q && scan) begin
            state_q  <= SAMPLE;
            ch_q     <= (ch_q == C_CH_LAST) ? '0 : ch_q + 1'b1;
            scnt_q   <= '0;
            sample_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dac_code     = eng_code;
  assign sample       = sample_q;
  assign ch           = ch_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_ch    = result_ch_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

endmodule

`default_nettype wire
